// File: rtl/tri_bus_arbiter_if.sv
// Request/enable bundle between the requesting agents
// and the tri-state bus arbiter.
interface tri_bus_arbiter_if #(
  parameter int N = 4
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [N-1:0]   en;
  logic [IDW-1:0] owner;
  logic           busy;
  logic           turn;
  logic           preempt;

  modport master (
    output req,
    input  en,
    input  owner,
    input  busy,
    input  turn,
    input  preempt
  );

  modport slave (
    input  req,
    output en,
    output owner,
    output busy,
    output turn,
    output preempt
  );
endinterface

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner arbiter for a shared tri-state net with
// hold-timer preemption and an all-off turnaround gap.
module tri_bus_arbiter #(
  parameter int N           = 4,
  parameter int MAX_HOLD    = 8,
  parameter int TURN_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  tri_bus_arbiter_if.slave bus
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;
  localparam int HW  = $clog2(MAX_HOLD + 1);
  localparam int TW  = $clog2(TURN_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_TURN
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   en_q, en_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [TW-1:0]  tcnt_q, tcnt_d;
  logic           busy_q, busy_d;
  logic           turn_q, turn_d;
  logic           pre_q, pre_d;

  logic           any_req;
  logic           own_req;
  logic           others;
  logic           at_max;
  logic           found;
  logic [IDW-1:0] win;
  logic [IDW-1:0] kk;
  logic [N-1:0]   win_oh;
  logic [IDW-1:0] nxt_ptr;
  int             k;

  assign any_req = |bus.req;
  assign own_req = bus.req[owner_q];
  // en_q is the owner's one-hot while granted
  assign others  = |(bus.req & ~en_q);
  assign at_max  = (hold_q == HW'(MAX_HOLD));
  assign win_oh  = {{(N-1){1'b0}}, 1'b1} << win;
  assign nxt_ptr = (owner_q == IDW'(N - 1)) ?
                   '0 : owner_q + IDW'(1);

  always_comb begin
    found = 1'b0;
    win   = '0;
    k     = 0;
    kk    = '0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr_q) + i;
      if (k >= N) k = k - N;
      kk = IDW'(k);
      if (!found && bus.req[kk]) begin
        found = 1'b1;
        win   = kk;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    tcnt_d  = tcnt_q;
    turn_d  = 1'b0;
    pre_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_GRANT;
          en_d    = win_oh;
          owner_d = win;
          hold_d  = HW'(1);
        end
      end
      S_GRANT: begin
        if (!own_req || (at_max && others)) begin
          state_d = S_TURN;
          en_d    = '0;
          ptr_d   = nxt_ptr;
          tcnt_d  = TW'(TURN_CYCLES);
          turn_d  = 1'b1;
          pre_d   = own_req;
        end else if (!at_max) begin
          hold_d = hold_q + HW'(1);
        end
      end
      S_TURN: begin
        if (tcnt_q == TW'(1)) begin
          if (any_req) begin
            state_d = S_GRANT;
            en_d    = win_oh;
            owner_d = win;
            hold_d  = HW'(1);
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          tcnt_d = tcnt_q - TW'(1);
          turn_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        en_d    = '0;
      end
    endcase
    busy_d = |en_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      en_q    <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      tcnt_q  <= '0;
      busy_q  <= 1'b0;
      turn_q  <= 1'b0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      tcnt_q  <= tcnt_d;
      busy_q  <= busy_d;
      turn_q  <= turn_d;
      pre_q   <= pre_d;
    end
  end

  assign bus.en      = en_q;
  assign bus.owner   = owner_q;
  assign bus.busy    = busy_q;
  assign bus.turn    = turn_q;
  assign bus.preempt = pre_q;
endmodule
